mem_lsu: RTL and testbench
==========================

# mem_lsu

Memory-stage load/store unit sitting directly downstream of `ex_alu`: it consumes the ALU result `ALU_DataC` as an effective address (or as a pass-through result), runs a req/ack transaction with data memory for loads and stores, and presents registered write-back results. It also back-pressures the EX stage while a memory transaction is outstanding.

## Interface
Parameters: none.

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `ex_valid` in 1: EX stage presents an instruction.
- `ex_ready` out 1: stage can accept; a transfer occurs on an edge where `ex_valid & ex_ready`.
- `ex_mem_rd` in 1: instruction is a load.
- `ex_mem_wr` in 1: instruction is a store.
- `ex_funct3` in 3: RV32I funct3 of the load/store.
- `ALU_DataC` in 32: ALU result; effective address for memory ops, result otherwise.
- `ex_store_data` in 32: rs2 value for stores.
- `ex_rd` in 5: destination register.
- `ex_reg_we` in 1: instruction writes rd.
- `dmem_req` out 1: memory request, held until ack.
- `dmem_we` out 1: 1 = write.
- `dmem_addr` out 32: word-aligned address ({addr[31:2],2'b00}).
- `dmem_wstrb` out 4: byte-lane write strobes.
- `dmem_wdata` out 32: lane-replicated store data.
- `dmem_ack` in 1: memory completes request this cycle.
- `dmem_rdata` in 32: read word, valid when `dmem_ack`.
- `wb_valid` out 1: one-cycle pulse, write-back result valid.
- `wb_rd` out 5, `wb_reg_we` out 1, `wb_data` out 32: write-back fields.
- `lsu_fault` out 1: one-cycle pulse with `wb_valid` for misaligned/illegal access.

## Operation
- FSM: IDLE, BUSY. `ex_ready = (state == IDLE)`.
- IDLE, accept of non-memory op (`ex_mem_rd = ex_mem_wr = 0`): next cycle `wb_valid=1`, `wb_data=ALU_DataC`, `wb_rd`, `wb_reg_we` copied; stay IDLE.
- IDLE, accept of legal aligned memory op: register addr, funct3, rd, lane data; go BUSY; `dmem_req=1` from the next cycle.
- BUSY: `dmem_req`, `dmem_we`, `dmem_addr`, `dmem_wstrb`, `dmem_wdata` held stable until an edge with `dmem_ack=1`; on that edge go IDLE and produce write-back in the following cycle.
- Loads (funct3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU): select byte/half by addr[1:0] from `dmem_rdata`; sign-extend LB/LH, zero-extend LBU/LHU. `wb_reg_we = ex_reg_we`. `dmem_wstrb = 0`.
- Stores (000 SB, 001 SH, 010 SW): `dmem_wstrb` = 0001/0011/1111 shifted left by addr[1:0]; `dmem_wdata` = {4{b}}, {2{h}}, word. Write-back: `wb_valid=1`, `wb_reg_we=0`, `wb_data=0`.
- Faults, detected at accept, no memory request issued: halfword with addr[0]=1; word with addr[1:0]≠0; illegal funct3 (load 011/110/111, store 011–111); `ex_mem_rd & ex_mem_wr`. Next cycle `wb_valid=1`, `lsu_fault=1`, `wb_reg_we=0`, `wb_data=ALU_DataC` (faulting address); stay IDLE.
- `dmem_ack` while not BUSY is ignored.

## Timing
- Reset: state IDLE; `dmem_req`, `dmem_we`, `dmem_wstrb`, `wb_valid`, `wb_reg_we`, `lsu_fault` = 0; `dmem_addr`, `dmem_wdata`, `wb_data`, `wb_rd` = 0. `ex_ready=1` after reset. Inputs ignored while `rst=1`.
- Non-memory/fault latency: accept edge N → `wb_valid` during cycle N+1; back-to-back accepts every cycle.
- Memory op: accept edge N → `dmem_req` cycle N+1; ack sampled at edge M ≥ N+1 → `wb_valid` cycle M+1, `ex_ready=1` cycle M+1; next accept at edge M+1 earliest. Minimum load/store latency 2 cycles (ack in first req cycle).
- `wb_valid`/`lsu_fault` are single-cycle pulses; `wb_*` data fields hold last value otherwise.
- Reset mid-transaction: `dmem_req` drops the cycle after the reset edge, no write-back produced, later stray ack ignored.

## Test plan
- ALU op: accept `ALU_DataC=0x0000_1234`, rd=5, we=1 → next cycle `wb_valid=1`, `wb_data=0x1234`, `wb_rd=5`; three consecutive accepts give three consecutive pulses.
- LB addr 0x103, `dmem_rdata=0x80_00_00_00`, ack after 3 wait cycles → `dmem_addr=0x100` held 4 cycles, `wb_data=0xFFFF_FF80`; LBU same → `0x0000_0080`.
- SH addr 0x202, data 0xAAAA_BEEF, immediate ack → `dmem_we=1`, `dmem_wstrb=1100`, `dmem_wdata=0xBEEF_BEEF`, `wb_reg_we=0`; `ex_ready=0` only during req cycle.
- LW addr 0x101 → no `dmem_req`, next cycle `wb_valid=1`, `lsu_fault=1`, `wb_data=0x101`, `wb_reg_we=0`; same for funct3=011 load.
- Assert `rst` in second BUSY cycle of a load → `dmem_req=0` next cycle, no `wb_valid`, subsequent `dmem_ack` pulse has no effect; `ex_ready=1`.

Source files
------------

// File: rtl/mem_lsu.sv
// Memory-stage load/store unit: pass-through ALU results, aligned loads/stores via req/ack, faults at accept.
// Latency: one cycle for non-memory ops and faults, at least two for memory ops; ex_ready stays low while a request is outstanding.
module mem_lsu (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic        ex_mem_rd,
    input  logic        ex_mem_wr,
    input  logic [2:0]  ex_funct3,
    input  logic [31:0] ALU_DataC,
    input  logic [31:0] ex_store_data,
    input  logic [4:0]  ex_rd,
    input  logic        ex_reg_we,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_wstrb,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic        wb_reg_we,
    output logic [31:0] wb_data,
    output logic        lsu_fault
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state_q;
    logic        req_q, we_q, wb_valid_q, wb_reg_we_q, fault_q, reg_we_q;
    logic [31:0] addr_q, wdata_q, wb_data_q;
    logic [3:0]  wstrb_q;
    logic [4:0]  wb_rd_q, rd_q;
    logic [2:0]  funct3_q;
    logic [1:0]  lo_q;

    logic        mem_op, f3_ok, misalign, acc_fault;
    logic [3:0]  st_strb;
    logic [31:0] st_wdata;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    assign mem_op = ex_mem_rd | ex_mem_wr;

    always_comb begin
        f3_ok    = 1'b0;
        misalign = 1'b0;
        if (ex_mem_wr)
            f3_ok = (ex_funct3 == 3'b000) || (ex_funct3 == 3'b001) || (ex_funct3 == 3'b010);
        else
            f3_ok = (ex_funct3 == 3'b000) || (ex_funct3 == 3'b001) || (ex_funct3 == 3'b010)
                 || (ex_funct3 == 3'b100) || (ex_funct3 == 3'b101);
        if (ex_funct3[1:0] == 2'b01)
            misalign = ALU_DataC[0];
        else if (ex_funct3[1:0] == 2'b10)
            misalign = (ALU_DataC[1:0] != 2'b00);
        acc_fault = (ex_mem_rd & ex_mem_wr) | ~f3_ok | misalign;
    end

    // Store lanes: strobe pattern shifted by the byte offset, data replicated across lanes.
    always_comb begin
        st_strb  = 4'b1111;
        st_wdata = ex_store_data;
        case (ex_funct3[1:0])
            2'b00: begin
                st_strb  = 4'b0001 << ALU_DataC[1:0];
                st_wdata = {4{ex_store_data[7:0]}};
            end
            2'b01: begin
                st_strb  = 4'b0011 << ALU_DataC[1:0];
                st_wdata = {2{ex_store_data[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        ld_byte = dmem_rdata[{lo_q, 3'b000} +: 8];
        ld_half = lo_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (funct3_q)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_data = {24'h0, ld_byte};
            3'b101:  ld_data = {16'h0, ld_half};
            default: ld_data = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wstrb_q     <= '0;
            wdata_q     <= '0;
            wb_valid_q  <= 1'b0;
            wb_rd_q     <= '0;
            wb_reg_we_q <= 1'b0;
            wb_data_q   <= '0;
            fault_q     <= 1'b0;
            rd_q        <= '0;
            reg_we_q    <= 1'b0;
            funct3_q    <= '0;
            lo_q        <= '0;
        end else begin
            wb_valid_q <= 1'b0;
            fault_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (ex_valid) begin
                        if (!mem_op) begin
                            wb_valid_q  <= 1'b1;
                            wb_data_q   <= ALU_DataC;
                            wb_rd_q     <= ex_rd;
                            wb_reg_we_q <= ex_reg_we;
                        end else if (acc_fault) begin
                            wb_valid_q  <= 1'b1;
                            fault_q     <= 1'b1;
                            wb_data_q   <= ALU_DataC;
                            wb_rd_q     <= ex_rd;
                            wb_reg_we_q <= 1'b0;
                        end else begin
                            state_q  <= BUSY;
                            req_q    <= 1'b1;
                            we_q     <= ex_mem_wr;
                            addr_q   <= {ALU_DataC[31:2], 2'b00};
                            wstrb_q  <= ex_mem_wr ? st_strb : 4'b0000;
                            wdata_q  <= ex_mem_wr ? st_wdata : 32'h0;
                            funct3_q <= ex_funct3;
                            lo_q     <= ALU_DataC[1:0];
                            rd_q     <= ex_rd;
                            reg_we_q <= ex_mem_rd & ex_reg_we;
                        end
                    end
                end
                BUSY: begin
                    if (dmem_ack) begin
                        state_q     <= IDLE;
                        req_q       <= 1'b0;
                        we_q        <= 1'b0;
                        wstrb_q     <= 4'b0000;
                        wb_valid_q  <= 1'b1;
                        wb_rd_q     <= rd_q;
                        wb_reg_we_q <= reg_we_q;
                        wb_data_q   <= we_q ? 32'h0 : ld_data;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ex_ready   = (state_q == IDLE);
    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_wstrb = wstrb_q;
    assign dmem_wdata = wdata_q;
    assign wb_valid   = wb_valid_q;
    assign wb_rd      = wb_rd_q;
    assign wb_reg_we  = wb_reg_we_q;
    assign wb_data    = wb_data_q;
    assign lsu_fault  = fault_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: inputs change and outputs are sampled on the falling edge.
module tb_mem_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_ready, ex_mem_rd, ex_mem_wr, ex_reg_we;
    logic [2:0]  ex_funct3;
    logic [31:0] ALU_DataC, ex_store_data;
    logic [4:0]  ex_rd;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_wstrb;
    logic        wb_valid, wb_reg_we, lsu_fault;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_lsu dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr), .ex_funct3(ex_funct3),
        .ALU_DataC(ALU_DataC), .ex_store_data(ex_store_data),
        .ex_rd(ex_rd), .ex_reg_we(ex_reg_we),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wstrb(dmem_wstrb), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_reg_we(wb_reg_we),
        .wb_data(wb_data), .lsu_fault(lsu_fault)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic rd_op, input logic wr_op, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] sd,
                         input logic [4:0] rd, input logic we);
        ex_valid      = 1'b1;
        ex_mem_rd     = rd_op;
        ex_mem_wr     = wr_op;
        ex_funct3     = f3;
        ALU_DataC     = a;
        ex_store_data = sd;
        ex_rd         = rd;
        ex_reg_we     = we;
    endtask

    // Load with 'waits' non-ack request cycles before the acking one.
    task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] rdata, input int waits, input logic [31:0] exp);
        drive(1'b1, 1'b0, f3, a, 32'h0, 5'd7, 1'b1);
        @(negedge clk);
        ex_valid = 1'b0;
        for (int k = 0; k <= waits; k++) begin
            chk({tag, "_req"},   32'(dmem_req), 32'd1);
            chk({tag, "_addr"},  dmem_addr, {a[31:2], 2'b00});
            chk({tag, "_rdy"},   32'(ex_ready), 32'd0);
            if (k == waits) begin
                chk({tag, "_strb"}, 32'(dmem_wstrb), 32'd0);
                dmem_ack   = 1'b1;
                dmem_rdata = rdata;
            end
            @(negedge clk);
        end
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
        chk({tag, "_wbv"},  32'(wb_valid), 32'd1);
        chk({tag, "_data"}, wb_data, exp);
        chk({tag, "_rd"},   32'(wb_rd), 32'd7);
        chk({tag, "_we"},   32'(wb_reg_we), 32'd1);
        chk({tag, "_rdy2"}, 32'(ex_ready), 32'd1);
        chk({tag, "_req2"}, 32'(dmem_req), 32'd0);
    endtask

    task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] sd, input logic [3:0] exp_strb,
                            input logic [31:0] exp_wdata);
        drive(1'b0, 1'b1, f3, a, sd, 5'd9, 1'b1);
        @(negedge clk);
        ex_valid = 1'b0;
        chk({tag, "_req"},  32'(dmem_req), 32'd1);
        chk({tag, "_we"},   32'(dmem_we), 32'd1);
        chk({tag, "_addr"}, dmem_addr, {a[31:2], 2'b00});
        chk({tag, "_strb"}, 32'(dmem_wstrb), 32'(exp_strb));
        chk({tag, "_wdat"}, dmem_wdata, exp_wdata);
        chk({tag, "_rdy"},  32'(ex_ready), 32'd0);
        dmem_ack = 1'b1;
        @(negedge clk);
        dmem_ack = 1'b0;
        chk({tag, "_wbv"},  32'(wb_valid), 32'd1);
        chk({tag, "_wbwe"}, 32'(wb_reg_we), 32'd0);
        chk({tag, "_wbd"},  wb_data, 32'h0);
        chk({tag, "_rdy2"}, 32'(ex_ready), 32'd1);
        chk({tag, "_req2"}, 32'(dmem_req), 32'd0);
    endtask

    task automatic do_fault(input string tag, input logic rd_op, input logic wr_op,
                            input logic [2:0] f3, input logic [31:0] a);
        drive(rd_op, wr_op, f3, a, 32'h5555_5555, 5'd3, 1'b1);
        @(negedge clk);
        ex_valid = 1'b0;
        chk({tag, "_req"},   32'(dmem_req), 32'd0);
        chk({tag, "_wbv"},   32'(wb_valid), 32'd1);
        chk({tag, "_fault"}, 32'(lsu_fault), 32'd1);
        chk({tag, "_data"},  wb_data, a);
        chk({tag, "_we"},    32'(wb_reg_we), 32'd0);
        chk({tag, "_rdy"},   32'(ex_ready), 32'd1);
        @(negedge clk);
        chk({tag, "_pulse"}, 32'(lsu_fault), 32'd0);
    endtask

    logic [31:0] alu_vals [3];

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        alu_vals[0] = 32'h0000_0011;
        alu_vals[1] = 32'h0000_0022;
        alu_vals[2] = 32'h0000_0033;
        rst = 1'b1;
        dmem_ack = 1'b0;
        dmem_rdata = 32'h0;
        // Inputs active during reset must be ignored.
        drive(1'b1, 1'b0, 3'b010, 32'h0000_0040, 32'h0, 5'd1, 1'b1);
        dmem_ack = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        ex_valid = 1'b0;
        dmem_ack = 1'b0;
        chk("rst_rdy",   32'(ex_ready), 32'd1);
        chk("rst_req",   32'(dmem_req), 32'd0);
        chk("rst_wbv",   32'(wb_valid), 32'd0);
        chk("rst_wbd",   wb_data, 32'h0);
        chk("rst_addr",  dmem_addr, 32'h0);
        chk("rst_fault", 32'(lsu_fault), 32'd0);

        // ALU pass-through
        drive(1'b0, 1'b0, 3'b000, 32'h0000_1234, 32'h0, 5'd5, 1'b1);
        @(negedge clk);
        ex_valid = 1'b0;
        chk("alu_wbv", 32'(wb_valid), 32'd1);
        chk("alu_wbd", wb_data, 32'h0000_1234);
        chk("alu_rd",  32'(wb_rd), 32'd5);
        chk("alu_we",  32'(wb_reg_we), 32'd1);
        @(negedge clk);
        chk("alu_pulse", 32'(wb_valid), 32'd0);
        chk("alu_hold",  wb_data, 32'h0000_1234);

        // Three back-to-back ALU accepts
        drive(1'b0, 1'b0, 3'b000, alu_vals[0], 32'h0, 5'd1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("b2b_wbv", 32'(wb_valid), 32'd1);
            chk("b2b_wbd", wb_data, alu_vals[i]);
            chk("b2b_rd",  32'(wb_rd), 32'(i + 1));
            if (i < 2) drive(1'b0, 1'b0, 3'b000, alu_vals[i + 1], 32'h0, 5'(i + 2), 1'b1);
            else ex_valid = 1'b0;
        end
        @(negedge clk);
        chk("b2b_end", 32'(wb_valid), 32'd0);

        // Loads
        do_load("lb",  3'b000, 32'h0000_0103, 32'h8000_0000, 3, 32'hFFFF_FF80);
        do_load("lbu", 3'b100, 32'h0000_0103, 32'h8000_0000, 3, 32'h0000_0080);
        do_load("lh",  3'b001, 32'h0000_0102, 32'h8001_7F00, 1, 32'hFFFF_8001);
        do_load("lhu", 3'b101, 32'h0000_0102, 32'h8001_7F00, 0, 32'h0000_8001);
        do_load("lbl", 3'b000, 32'h0000_0101, 32'h1234_7F56, 0, 32'h0000_007F);
        do_load("lw",  3'b010, 32'h0000_0104, 32'hDEAD_BEEF, 2, 32'hDEAD_BEEF);

        // Stores
        do_store("sh", 3'b001, 32'h0000_0202, 32'hAAAA_BEEF, 4'b1100, 32'hBEEF_BEEF);
        do_store("sb", 3'b000, 32'h0000_0301, 32'h1234_5678, 4'b0010, 32'h7878_7878);
        do_store("sw", 3'b010, 32'h0000_0400, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D);

        // Faults
        do_fault("f_lw",    1'b1, 1'b0, 3'b010, 32'h0000_0101);
        do_fault("f_ld011", 1'b1, 1'b0, 3'b011, 32'h0000_0040);
        do_fault("f_lh",    1'b1, 1'b0, 3'b101, 32'h0000_0203);
        do_fault("f_st100", 1'b0, 1'b1, 3'b100, 32'h0000_0080);
        do_fault("f_both",  1'b1, 1'b1, 3'b010, 32'h0000_0100);

        // Stray ack while idle
        dmem_ack = 1'b1;
        @(negedge clk);
        dmem_ack = 1'b0;
        chk("stray_wbv", 32'(wb_valid), 32'd0);
        chk("stray_req", 32'(dmem_req), 32'd0);

        // Reset in second BUSY cycle of a load
        drive(1'b1, 1'b0, 3'b010, 32'h0000_0010, 32'h0, 5'd4, 1'b1);
        @(negedge clk);
        ex_valid = 1'b0;
        chk("mr_req1", 32'(dmem_req), 32'd1);
        @(negedge clk);
        chk("mr_req2", 32'(dmem_req), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mr_req",  32'(dmem_req), 32'd0);
        chk("mr_wbv",  32'(wb_valid), 32'd0);
        chk("mr_rdy",  32'(ex_ready), 32'd1);
        chk("mr_wbd",  wb_data, 32'h0);
        dmem_ack = 1'b1;
        dmem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        dmem_ack = 1'b0;
        chk("mr_ack_wbv", 32'(wb_valid), 32'd0);
        chk("mr_ack_req", 32'(dmem_req), 32'd0);
        chk("mr_ack_rdy", 32'(ex_ready), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
